// File: rtl/io_port.sv
// io_port: debounced switch input port with LED output register and registered read interface
module io_port #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] switches,
   output logic [WIDTH-1:0] LEDs,
   input  logic             addr,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             changed
);
   localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] cand_q, cand_d;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [WIDTH-1:0] leds_q, leds_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             changed_q, changed_d;
   logic             rd_valid_q, rd_valid_d;
   logic             qualify;

   // Next state: the sample that restarts the count is itself the first stable
   // sample, so a change qualifies on the edge where the count reaches its maximum.
   // A qualifying change beats a same-edge data read clearing the sticky flag.
   always_comb begin
      cand_d     = sync2_q;
      cnt_d      = (sync2_q != cand_q) ? 8'd0 : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
      qualify    = (cnt_d == CNT_MAX) && (cand_d != stable_q);
      stable_d   = qualify ? cand_d : stable_q;
      changed_d  = qualify | (changed_q & ~(rd_en & ~addr));
      rd_valid_d = rd_en;
      rd_data_d  = rd_en ? (addr ? WIDTH'(changed_q) : stable_q) : rd_data_q;
      leds_d     = wr_en ? wr_data : leds_q;
   end

   // State registers including the two-flop switch synchronizer
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         cand_q     <= '0;
         cnt_q      <= '0;
         stable_q   <= '0;
         changed_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         leds_q     <= '0;
      end else begin
         sync1_q    <= switches;
         sync2_q    <= sync1_q;
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
         stable_q   <= stable_d;
         changed_q  <= changed_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         leds_q     <= leds_d;
      end
   end

   assign LEDs     = leds_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign changed  = changed_q;
endmodule

// File: tb/tb_io_port.sv
// tb_io_port: directed self-checking bench for io_port
module tb_io_port;
   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] switches = '0;
   logic [3:0] LEDs;
   logic       addr = 1'b0;
   logic       rd_en = 1'b0;
   logic [3:0] rd_data;
   logic       rd_valid;
   logic       wr_en = 1'b0;
   logic [3:0] wr_data = '0;
   logic       changed;
   int checks = 0;
   int errors = 0;

   io_port #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
      .clock(clock), .reset(reset), .switches(switches), .LEDs(LEDs),
      .addr(addr), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
      .wr_en(wr_en), .wr_data(wr_data), .changed(changed)
   );

   always #5 clock = ~clock;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      step(2);
      checks++; if (LEDs !== 4'h0) begin errors++; $display("FAIL reset_leds: got %h expected %h", LEDs, 4'h0); end
      checks++; if (rd_data !== 4'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected %h", rd_data, 4'h0); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
      checks++; if (changed !== 1'b0) begin errors++; $display("FAIL reset_changed: got %b expected 0", changed); end
      reset = 1'b1;
      rd_en = 1'b1; addr = 1'b0;
      step(1);
      rd_en = 1'b0;
      checks++; if (rd_data !== 4'h0) begin errors++; $display("FAIL reset_read_data: got %h expected %h", rd_data, 4'h0); end
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL reset_read_valid: got %b expected 1", rd_valid); end
   endtask

   task automatic test_glitch;
      switches = 4'b0011;
      step(2);
      switches = 4'b0000;
      step(10);
      checks++; if (changed !== 1'b0) begin errors++; $display("FAIL glitch_changed: got %b expected 0", changed); end
      rd_en = 1'b1; addr = 1'b0;
      step(1);
      rd_en = 1'b0;
      checks++; if (rd_data !== 4'b0000) begin errors++; $display("FAIL glitch_read: got %b expected %b", rd_data, 4'b0000); end
      step(1);
   endtask

   task automatic test_debounce;
      switches = 4'b0101;
      step(5);
      checks++; if (changed !== 1'b0) begin errors++; $display("FAIL deb_early_changed: got %b expected 0", changed); end
      step(1);
      checks++; if (changed !== 1'b1) begin errors++; $display("FAIL deb_edge6_changed: got %b expected 1", changed); end
      rd_en = 1'b1; addr = 1'b1;
      step(1);
      checks++; if (rd_data !== 4'b0001) begin errors++; $display("FAIL deb_status: got %b expected %b", rd_data, 4'b0001); end
      checks++; if (changed !== 1'b1) begin errors++; $display("FAIL deb_status_keeps: got %b expected 1", changed); end
      addr = 1'b0;
      step(1);
      checks++; if (rd_data !== 4'b0101) begin errors++; $display("FAIL deb_data: got %b expected %b", rd_data, 4'b0101); end
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL deb_data_valid: got %b expected 1", rd_valid); end
      rd_en = 1'b0;
      step(1);
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL deb_idle_valid: got %b expected 0", rd_valid); end
      checks++; if (rd_data !== 4'b0101) begin errors++; $display("FAIL deb_hold_data: got %b expected %b", rd_data, 4'b0101); end
      checks++; if (changed !== 1'b0) begin errors++; $display("FAIL deb_cleared: got %b expected 0", changed); end
   endtask

   task automatic test_write;
      checks++; if (LEDs !== 4'b0000) begin errors++; $display("FAIL wr_before: got %b expected %b", LEDs, 4'b0000); end
      wr_en = 1'b1; wr_data = 4'b1010; rd_en = 1'b1; addr = 1'b0;
      step(1);
      checks++; if (LEDs !== 4'b1010) begin errors++; $display("FAIL wr_leds: got %b expected %b", LEDs, 4'b1010); end
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL wr_rd_valid: got %b expected 1", rd_valid); end
      checks++; if (rd_data !== 4'b0101) begin errors++; $display("FAIL wr_rd_data: got %b expected %b", rd_data, 4'b0101); end
      wr_en = 1'b0; wr_data = 4'b0110; rd_en = 1'b0;
      step(1);
      checks++; if (LEDs !== 4'b1010) begin errors++; $display("FAIL wr_hold: got %b expected %b", LEDs, 4'b1010); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL wr_idle_valid: got %b expected 0", rd_valid); end
   endtask

   task automatic test_back_to_back;
      switches = 4'b1001;
      step(5);
      checks++; if (changed !== 1'b0) begin errors++; $display("FAIL b2b_early: got %b expected 0", changed); end
      rd_en = 1'b1; addr = 1'b0;
      step(1);
      checks++; if (rd_data !== 4'b0101) begin errors++; $display("FAIL b2b_old_data: got %b expected %b", rd_data, 4'b0101); end
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1: got %b expected 1", rd_valid); end
      checks++; if (changed !== 1'b1) begin errors++; $display("FAIL b2b_set_wins: got %b expected 1", changed); end
      step(1);
      checks++; if (rd_data !== 4'b1001) begin errors++; $display("FAIL b2b_new_data: got %b expected %b", rd_data, 4'b1001); end
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid2: got %b expected 1", rd_valid); end
      checks++; if (changed !== 1'b0) begin errors++; $display("FAIL b2b_cleared: got %b expected 0", changed); end
      rd_en = 1'b0;
      step(1);
   endtask

   task automatic test_reset_abort;
      switches = 4'b0000;
      step(6);
      checks++; if (changed !== 1'b1) begin errors++; $display("FAIL ra_zero_changed: got %b expected 1", changed); end
      rd_en = 1'b1; addr = 1'b0;
      step(1);
      rd_en = 1'b0;
      checks++; if (rd_data !== 4'b0000) begin errors++; $display("FAIL ra_zero_data: got %b expected %b", rd_data, 4'b0000); end
      step(1);
      switches = 4'b1111;
      step(2);
      reset = 1'b0;
      #1;
      checks++; if (LEDs !== 4'h0) begin errors++; $display("FAIL ra_async_leds: got %h expected %h", LEDs, 4'h0); end
      checks++; if (changed !== 1'b0) begin errors++; $display("FAIL ra_async_changed: got %b expected 0", changed); end
      step(2);
      reset = 1'b1;
      step(5);
      checks++; if (changed !== 1'b0) begin errors++; $display("FAIL ra_early: got %b expected 0", changed); end
      step(1);
      checks++; if (changed !== 1'b1) begin errors++; $display("FAIL ra_edge6: got %b expected 1", changed); end
      rd_en = 1'b1; addr = 1'b0;
      step(1);
      rd_en = 1'b0;
      checks++; if (rd_data !== 4'b1111) begin errors++; $display("FAIL ra_data: got %b expected %b", rd_data, 4'b1111); end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_debounce();
      test_write();
      test_back_to_back();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
